// File: rtl/weight_sched_pkg.sv
// Shared types and register map for the weight-type scheduler.
package weight_sched_pkg;

  localparam int unsigned N_NEURON = 16;
  localparam int unsigned N_AXON   = 16;
  localparam int unsigned NW       = 4;
  localparam int unsigned AW       = 4;
  localparam int unsigned TW       = 2;
  localparam int unsigned CNT_W    = 9;
  localparam int unsigned DW       = 32;

  localparam logic [7:0] OFF_TBL       = 8'h00;
  localparam logic [7:0] OFF_SPIKE     = 8'h40;
  localparam logic [7:0] OFF_CTRL      = 8'h44;
  localparam logic [7:0] OFF_EVT_COUNT = 8'h48;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_BUSY  = 1;
  localparam int unsigned CTRL_DONE  = 2;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_ROWEND} state_t;

  typedef struct packed {
    logic [NW-1:0] neuron;
    logic [AW-1:0] axon;
    logic [TW-1:0] wtype;
    logic          last;
  } evt_t;

  // Byte-lane merge for partial Wishbone writes.
  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [3:0]    sel);
    logic [DW-1:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/weight_sched_wb.sv
// Wishbone register file: weight table, spike vector, control/status, event count readback.
module weight_sched_wb
  import weight_sched_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_4000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cyc,
  input  logic             stb,
  input  logic             we,
  input  logic [3:0]       sel,
  input  logic [DW-1:0]    adr,
  input  logic [DW-1:0]    dat_w,
  output logic             ack,
  output logic [DW-1:0]    dat_r,
  input  logic             busy,
  input  logic             done_set_c,
  input  logic [CNT_W-1:0] evt_count,
  input  logic [NW-1:0]    rd_neuron,
  input  logic [AW-1:0]    rd_axon,
  output logic [TW-1:0]    rd_type_c,
  output logic [N_AXON-1:0] spike,
  output logic             start
);

  logic [DW-1:0] tbl [N_NEURON];
  logic          done;
  logic          req, wr, locked, is_tbl, wr_ctrl;
  logic [7:0]    off;
  logic [DW-1:0] rdata_c;
  logic [DW-1:0] row;
  logic [4:0]    bit_hi;

  assign off     = adr[7:0];
  assign req     = cyc & stb & ~ack & (adr[31:8] == BASE_ADDR[31:8]);
  assign wr      = req & we;
  assign is_tbl  = (off[7:6] == 2'b00) && (off[1:0] == 2'b00);
  assign wr_ctrl = wr && (off == OFF_CTRL);
  // A start already latched but not yet seen by the FSM also locks the table.
  assign locked  = busy | start;

  // Axon 0 lives in the word MSBs.
  assign row       = tbl[rd_neuron];
  assign bit_hi    = 5'd31 - {rd_axon, 1'b0};
  assign rd_type_c = row[bit_hi -: 2];

  always_comb begin
    rdata_c = '0;
    if (is_tbl) begin
      rdata_c = tbl[off[5:2]];
    end else begin
      case (off)
        OFF_SPIKE:     rdata_c = DW'(spike);
        OFF_CTRL: begin
          rdata_c[CTRL_BUSY] = busy;
          rdata_c[CTRL_DONE] = done;
        end
        OFF_EVT_COUNT: rdata_c = DW'(evt_count);
        default:       rdata_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      dat_r <= '0;
      spike <= '0;
      start <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < N_NEURON; i++) tbl[i] <= '0;
    end else begin
      ack   <= req;
      dat_r <= req ? rdata_c : '0;
      start <= wr_ctrl && dat_w[CTRL_START] && !locked;
      if (wr && !locked && is_tbl) tbl[off[5:2]] <= byte_merge(tbl[off[5:2]], dat_w, sel);
      if (wr && !locked && (off == OFF_SPIKE))
        spike <= N_AXON'(byte_merge(DW'(spike), dat_w, sel));
      // Completion wins over a same-cycle clear.
      if (done_set_c) done <= 1'b1;
      else if (wr_ctrl && (dat_w[CTRL_DONE] || (dat_w[CTRL_START] && !locked))) done <= 1'b0;
    end
  end

endmodule

// File: rtl/weight_type_sched.sv
// Sweeps the weight table per neuron and streams spike/END beats over valid/ready.
module weight_type_sched
  import weight_sched_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_4000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [DW-1:0] wbs_adr_i,
  input  logic [DW-1:0] wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic          evt_valid_o,
  input  logic          evt_ready_i,
  output logic [NW-1:0] evt_neuron_o,
  output logic [AW-1:0] evt_axon_o,
  output logic [TW-1:0] evt_type_o,
  output logic          evt_last_o,
  output logic          busy_o
);

  state_t            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [AW-1:0]     a_q, a_d;
  evt_t              evt_q, evt_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_set_c, hs_c, start;
  logic [TW-1:0]     type_c;
  logic [N_AXON-1:0] spike;

  weight_sched_wb #(.BASE_ADDR(BASE_ADDR)) u_wb (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_ni),
    .cyc        (wbs_cyc_i),
    .stb        (wbs_stb_i),
    .we         (wbs_we_i),
    .sel        (wbs_sel_i),
    .adr        (wbs_adr_i),
    .dat_w      (wbs_dat_i),
    .ack        (wbs_ack_o),
    .dat_r      (wbs_dat_o),
    .busy       (busy_q),
    .done_set_c (done_set_c),
    .evt_count  (cnt_q),
    .rd_neuron  (n_q),
    .rd_axon    (a_q),
    .rd_type_c  (type_c),
    .spike      (spike),
    .start      (start)
  );

  assign hs_c = valid_q & evt_ready_i;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    a_d        = a_q;
    evt_d      = evt_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    done_set_c = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_SCAN;
        n_d     = '0;
        a_d     = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      S_SCAN: begin
        if (spike[a_q]) begin
          evt_d   = '{neuron: n_q, axon: a_q, wtype: type_c, last: 1'b0};
          valid_d = 1'b1;
          state_d = S_EMIT;
        end else if (a_q == AW'(N_AXON - 1)) begin
          evt_d   = '{neuron: n_q, axon: '0, wtype: '0, last: 1'b1};
          valid_d = 1'b1;
          state_d = S_ROWEND;
        end else begin
          a_d = a_q + AW'(1);
        end
      end
      S_EMIT: if (hs_c) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (a_q == AW'(N_AXON - 1)) begin
          evt_d   = '{neuron: n_q, axon: '0, wtype: '0, last: 1'b1};
          state_d = S_ROWEND;
        end else begin
          a_d     = a_q + AW'(1);
          valid_d = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_ROWEND: if (hs_c) begin
        valid_d = 1'b0;
        if (n_q == NW'(N_NEURON - 1)) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          done_set_c = 1'b1;
        end else begin
          n_d     = n_q + NW'(1);
          a_d     = '0;
          state_d = S_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      a_q     <= '0;
      evt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      a_q     <= a_d;
      evt_q   <= evt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign evt_valid_o  = valid_q;
  assign evt_neuron_o = evt_q.neuron;
  assign evt_axon_o   = evt_q.axon;
  assign evt_type_o   = evt_q.wtype;
  assign evt_last_o   = evt_q.last;
  assign busy_o       = busy_q;

endmodule
